// File: rtl/smc_pkg.sv
// Shared types and sizing helpers for the streaming drain-current / transconductance
// evaluator.
package smc_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SUM,
        OUT
    } state_e;

    function automatic int calc_val_w(input int vw);
        int m;
        m = (1 << vw) - 1;
        return $clog2((m * m * m) / 3 + 1);
    endfunction

    function automatic int calc_out_w(input int vw, input int k);
        int s;
        s = 0;
        for (int j = 0; j < k; j++) begin
            s += 3 + j;
        end
        return calc_val_w(vw) + $clog2(s);
    endfunction

    // Id sums weight the selected elements 3,4,5,...; gm sums are unweighted.
    function automatic int unsigned weight(input int unsigned j, input logic mode0);
        return mode0 ? 3 + j : 1;
    endfunction

endpackage

// File: rtl/smc_cell_calc.sv
// Combinational per-transistor evaluator: Id or gm of one descriptor, floored
// after the divide by three.
module smc_cell_calc #(
    parameter int VW    = 3,
    parameter int VAL_W = 7
) (
    input  logic [VW-1:0]    w_i,
    input  logic [VW-1:0]    vgs_i,
    input  logic [VW-1:0]    vds_i,
    input  logic             is_id_i,
    output logic [VAL_W-1:0] value_o
);

    localparam int PW = 3 * VW + 2;

    logic [PW-1:0] w;
    logic [PW-1:0] vds;
    logic [PW-1:0] ov;
    logic [PW-1:0] prod;

    assign w   = PW'(w_i);
    assign vds = PW'(vds_i);
    // Wraps when vgs_i is zero, but that case is forced to cutoff below.
    assign ov  = PW'(vgs_i) - PW'(1);

    always_comb begin
        prod = '0;
        if (vgs_i != '0) begin
            if (ov > vds) begin
                prod = is_id_i ? w * vds * ((ov << 1) - vds) : (w * vds) << 1;
            end else begin
                prod = is_id_i ? w * ov * ov : (w * ov) << 1;
            end
        end
    end

    assign value_o = VAL_W'(prod / PW'(3));

endmodule

// File: rtl/smc_stream.sv
// Streaming frame evaluator: inserts each accepted element into a descending sorted
// array, then sums a weighted top-K or bottom-K window over K cycles.
module smc_stream
    import smc_pkg::*;
#(
    parameter int N_CH = 6,
    parameter int K    = 3,
    parameter int VW   = 3,
    localparam int VAL_W = calc_val_w(VW),
    localparam int OUT_W = calc_out_w(VW, K)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       mode,
    input  logic [VW-1:0]    W,
    input  logic [VW-1:0]    V_GS,
    input  logic [VW-1:0]    V_DS,
    output logic             out_valid,
    output logic [OUT_W-1:0] out_n
);

    localparam int CW = $clog2(N_CH + 1);
    localparam int JW = $clog2(K + 1);
    localparam int IW = (N_CH > 1) ? $clog2(N_CH) : 1;

    state_e           state_q;
    logic [1:0]       mode_q;
    logic [CW-1:0]    cnt_q;
    logic [JW-1:0]    j_q;
    logic [OUT_W-1:0] acc_q;
    logic [OUT_W-1:0] acc_d;
    logic             out_valid_q;
    logic [OUT_W-1:0] out_n_q;
    logic [VAL_W-1:0] sorted_q [N_CH];
    logic [VAL_W-1:0] sorted_d [N_CH];

    logic             accept;
    logic             cell_is_id;
    logic [VAL_W-1:0] new_val;
    logic [N_CH-1:0]  keep;
    logic [IW-1:0]    sel_idx;

    assign in_ready  = (state_q == IDLE) || (state_q == LOAD);
    assign accept    = in_valid && in_ready;
    assign out_valid = out_valid_q;
    assign out_n     = out_n_q;

    // The first element of a frame is evaluated with the live mode, later ones with the latched copy.
    assign cell_is_id = (state_q == IDLE) ? mode[0] : mode_q[0];

    smc_cell_calc #(
        .VW   (VW),
        .VAL_W(VAL_W)
    ) u_calc (
        .w_i    (W),
        .vgs_i  (V_GS),
        .vds_i  (V_DS),
        .is_id_i(cell_is_id),
        .value_o(new_val)
    );

    // Occupied slots holding a value >= the newcomer stay put, so ties land after existing equals.
    always_comb begin
        keep = '0;
        for (int i = 0; i < N_CH; i++) begin
            keep[i] = (CW'(i) < cnt_q) && (sorted_q[i] >= new_val);
        end
        for (int i = 0; i < N_CH; i++) begin
            if (keep[i]) begin
                sorted_d[i] = sorted_q[i];
            end else if ((i == 0) || keep[(i == 0) ? 0 : i - 1]) begin
                sorted_d[i] = new_val;
            end else begin
                sorted_d[i] = sorted_q[(i == 0) ? 0 : i - 1];
            end
        end
    end

    assign sel_idx = mode_q[1] ? IW'(j_q) : IW'(N_CH - K) + IW'(j_q);
    assign acc_d   = acc_q + OUT_W'(weight(32'(j_q), mode_q[0])) * OUT_W'(sorted_q[sel_idx]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            mode_q      <= '0;
            cnt_q       <= '0;
            j_q         <= '0;
            acc_q       <= '0;
            out_valid_q <= 1'b0;
            out_n_q     <= '0;
            for (int i = 0; i < N_CH; i++) begin
                sorted_q[i] <= '0;
            end
        end else begin
            out_valid_q <= 1'b0;
            out_n_q     <= '0;
            case (state_q)
                IDLE, LOAD: begin
                    if (accept) begin
                        if (state_q == IDLE) begin
                            mode_q <= mode;
                        end
                        for (int i = 0; i < N_CH; i++) begin
                            sorted_q[i] <= sorted_d[i];
                        end
                        cnt_q   <= cnt_q + 1'b1;
                        state_q <= (cnt_q + 1'b1 == CW'(N_CH)) ? SUM : LOAD;
                    end
                end
                SUM: begin
                    acc_q <= acc_d;
                    j_q   <= j_q + 1'b1;
                    if (j_q == JW'(K - 1)) begin
                        state_q     <= OUT;
                        out_valid_q <= 1'b1;
                        out_n_q     <= acc_d;
                    end
                end
                OUT: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                    j_q     <= '0;
                    acc_q   <= '0;
                    for (int i = 0; i < N_CH; i++) begin
                        sorted_q[i] <= '0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_smc_stream.sv
// Randomised self-checking bench for smc_stream against a sort-and-sum reference
// model built from the device equations.
module tb_smc_stream;
    import smc_pkg::*;

    localparam int N_CH   = 6;
    localparam int K      = 3;
    localparam int VW     = 3;
    localparam int VAL_W  = calc_val_w(VW);
    localparam int OUT_W  = calc_out_w(VW, K);
    localparam int PERIOD = 10;

    logic             clk      = 1'b0;
    logic             rst_n    = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [1:0]       mode     = '0;
    logic [VW-1:0]    W        = '0;
    logic [VW-1:0]    V_GS     = '0;
    logic [VW-1:0]    V_DS     = '0;
    logic             out_valid;
    logic [OUT_W-1:0] out_n;

    logic [VW-1:0]    cellW    = '0;
    logic [VW-1:0]    cellVgs  = '0;
    logic [VW-1:0]    cellVds  = '0;
    logic             cellIsId = 1'b0;
    logic [VAL_W-1:0] cellValue;

    int  checkCount = 0;
    int  errorCount = 0;
    int  expQ[$];
    time lastAcceptTime = 0;
    bit  monitorOn = 1'b0;

    logic [VW-1:0] fw[N_CH];
    logic [VW-1:0] fg[N_CH];
    logic [VW-1:0] fd[N_CH];
    logic [1:0]    fm[N_CH];

    always #(PERIOD / 2) clk = ~clk;

    smc_stream #(
        .N_CH(N_CH),
        .K   (K),
        .VW  (VW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .mode     (mode),
        .W        (W),
        .V_GS     (V_GS),
        .V_DS     (V_DS),
        .out_valid(out_valid),
        .out_n    (out_n)
    );

    smc_cell_calc #(
        .VW   (VW),
        .VAL_W(VAL_W)
    ) refCell (
        .w_i    (cellW),
        .vgs_i  (cellVgs),
        .vds_i  (cellVds),
        .is_id_i(cellIsId),
        .value_o(cellValue)
    );

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    function automatic int refValue(input int w, input int vgs, input int vds, input bit isId);
        int ov;
        if (vgs == 0) return 0;
        ov = vgs - 1;
        if (ov > vds) return isId ? (w * vds * (2 * ov - vds)) / 3 : (2 * w * vds) / 3;
        return isId ? (w * ov * ov) / 3 : (2 * w * ov) / 3;
    endfunction

    function automatic int refFrame(input logic [1:0] m);
        int v[N_CH];
        int t;
        int sum;
        sum = 0;
        for (int i = 0; i < N_CH; i++) v[i] = refValue(fw[i], fg[i], fd[i], m[0]);
        for (int a = 0; a < N_CH; a++) begin
            for (int b = 0; b < N_CH - 1 - a; b++) begin
                if (v[b] < v[b + 1]) begin
                    t = v[b]; v[b] = v[b + 1]; v[b + 1] = t;
                end
            end
        end
        for (int j = 0; j < K; j++) begin
            sum += (m[0] ? 3 + j : 1) * v[m[1] ? j : N_CH - K + j];
        end
        return sum;
    endfunction

    task automatic fillTable(input logic [1:0] m);
        int tw[N_CH];
        int tg[N_CH];
        int td[N_CH];
        tw = '{3, 6, 1, 2, 7, 3};
        tg = '{4, 3, 7, 2, 7, 5};
        td = '{5, 1, 7, 0, 2, 4};
        for (int i = 0; i < N_CH; i++) begin
            fw[i] = VW'(tw[i]);
            fg[i] = VW'(tg[i]);
            fd[i] = VW'(td[i]);
            fm[i] = m;
        end
    endtask

    task automatic fillRandom(input logic [1:0] m, input bit flip, input bit zeroVgs);
        for (int i = 0; i < N_CH; i++) begin
            fw[i] = VW'($urandom);
            fg[i] = zeroVgs ? '0 : VW'($urandom);
            fd[i] = VW'($urandom);
            fm[i] = (flip && i > 0) ? 2'($urandom) : m;
        end
    endtask

    // Called at a falling edge; returns at the falling edge after the accepting edge.
    task automatic applyStimulus(input logic [VW-1:0] w, input logic [VW-1:0] g,
                                 input logic [VW-1:0] d, input logic [1:0] m);
        int guard;
        guard = 0;
        in_valid = 1'b1;
        W = w; V_GS = g; V_DS = d; mode = m;
        while (in_ready !== 1'b1 && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        if (in_ready !== 1'b1) begin
            checkOutput("readyTimeout", {63'd0, in_ready}, 64'd1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        lastAcceptTime = $time;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic sendFrame(input int gapMax, input int expected);
        expQ.push_back(expected);
        for (int i = 0; i < N_CH; i++) begin
            if (i > 0) repeat ($urandom_range(0, gapMax)) @(negedge clk);
            applyStimulus(fw[i], fg[i], fd[i], fm[i]);
        end
    endtask

    // Junk offered while the frame is summed and reported must be ignored.
    task automatic applyJunk(input int n);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            W = VW'($urandom); V_GS = VW'($urandom); V_DS = VW'($urandom); mode = 2'($urandom);
            checkOutput("readyLowBusy", {63'd0, in_ready}, 64'd0);
            @(negedge clk);
        end
        in_valid = 1'b0;
        checkOutput("readyBack", {63'd0, in_ready}, 64'd1);
    endtask

    always @(negedge clk) begin
        if (monitorOn) begin
            if (out_valid) begin
                if (expQ.size() == 0) checkOutput("unexpectedStrobe", 64'd1, 64'd0);
                else checkOutput("frameResult", 64'(out_n), 64'(expQ.pop_front()));
                checkOutput("latency", 64'($time - lastAcceptTime), 64'(K * PERIOD + PERIOD / 2));
            end else begin
                checkOutput("outIdleZero", 64'(out_n), 64'd0);
            end
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog expired at %0t", $time);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        checkOutput("resetOutValid", {63'd0, out_valid}, 64'd0);
        checkOutput("resetOutN", 64'(out_n), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("resetReady", {63'd0, in_ready}, 64'd1);
        monitorOn = 1'b1;

        for (int i = 0; i < 40; i++) begin
            cellW = VW'($urandom); cellVgs = VW'($urandom); cellVds = VW'($urandom);
            cellIsId = 1'($urandom);
            #1;
            checkOutput("cellValue", 64'(cellValue), 64'(refValue(cellW, cellVgs, cellVds, cellIsId)));
        end
        @(negedge clk);

        fillTable(2'b11); sendFrame(0, 262);
        fillTable(2'b01); sendFrame(0, 51);
        fillTable(2'b10); sendFrame(0, 23);
        fillTable(2'b00); sendFrame(0, 8);

        fillRandom(2'($urandom), 1'b0, 1'b1); sendFrame(1, 0);

        fillTable(2'b11);
        fm[3] = 2'b00; fm[4] = 2'b10; fm[5] = 2'b01;
        sendFrame(3, 262);
        applyJunk(K + 1);
        fillTable(2'b10);
        fm[2] = 2'b11; fm[5] = 2'b01;
        sendFrame(0, 23);
        applyJunk(K + 1);

        fillTable(2'b11);
        for (int i = 0; i < 3; i++) applyStimulus(fw[i], fg[i], fd[i], fm[i]);
        rst_n = 1'b0;
        #1;
        checkOutput("midResetOutValid", {63'd0, out_valid}, 64'd0);
        checkOutput("midResetReady", {63'd0, in_ready}, 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        fillTable(2'b01); sendFrame(0, 51);

        for (int f = 0; f < 25; f++) begin
            fillRandom(2'($urandom), 1'($urandom), 1'b0);
            sendFrame($urandom_range(0, 2), refFrame(fm[0]));
            if ($urandom_range(0, 1) == 1) applyJunk(K + 1);
        end

        repeat (K + 4) @(negedge clk);
        checkOutput("pendingResults", 64'(expQ.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/smc_stream.md
Name: smc_stream

Overview:
- Sequential, parametrised successor to the six-transistor combinational drain-current/transconductance evaluator.
- Accepts N_CH transistor descriptors serially over a valid/ready handshake and computes Id or gm for each one.
- Maintains a sorted register array by insertion, then accumulates a weighted sum of the top-K or bottom-K values over K cycles.
- Sits between the stimulus front-end and the result checker in the lab datapath.

Parameters:
N_CH, 6, transistors per frame (>= K)
K, 3, elements selected for the output sum (1..N_CH)
VW, 3, bit width of W, V_GS and V_DS
VAL_W (localparam), $clog2(((2**VW-1)**3)/3+1), per-element value width
OUT_W (localparam), VAL_W+$clog2(sum of weights 3..K+2), out_n width

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  descriptor valid
in_ready  out  1  high in IDLE and LOAD
mode  in  2  [0]=1 Id, 0 gm; [1]=1 top-K, 0 bottom-K; sampled on the first accepted element of a frame
W  in  VW  channel width
V_GS  in  VW  gate-source voltage
V_DS  in  VW  drain-source voltage
out_valid  out  1  one-cycle result strobe
out_n  out  OUT_W  result; 0 whenever out_valid is low

Behaviour:
- Accept on in_valid && in_ready. Gaps in in_valid are allowed within a frame. in_valid is ignored (element dropped) in SUM and OUT.
- Per-element value: ov = V_GS-1.
  - V_GS==0: cutoff, value 0.
  - Triode when ov > V_DS: gm = floor(2*W*V_DS/3); Id = floor(W*V_DS*(2*ov-V_DS)/3).
  - Otherwise saturation: gm = floor(2*W*ov/3); Id = floor(W*ov*ov/3).
  - Products are computed at full width. Each value is floored individually before summation.
- Sorted array: N_CH x VAL_W registers, descending order. The new element is inserted at the edge on which it is accepted. Elements below the insertion point shift down one slot. On ties the new element goes after existing equal values.
- States:
  - IDLE: array cleared, cnt=0, acc=0. The first accept latches mode and goes to LOAD (or to SUM if N_CH==1).
  - LOAD: the accept making cnt==N_CH goes to SUM.
  - SUM: K cycles, index j=0..K-1.
    - Top-K: acc += weight(j) * sorted[j].
    - Bottom-K: acc += weight(j) * sorted[N_CH-K+j].
    - weight(j) = 3+j in Id mode, 1 in gm mode.
    - After j==K-1, go to OUT.
  - OUT: out_valid=1 and out_n=acc for one cycle, then back to IDLE with the array and acc cleared.
- Latency: last element accepted at edge t; out_valid is high in cycle t+K+1 (t+4 at default parameters). in_ready goes high again the cycle after OUT, so back-to-back frames are allowed.
- Reset: async; all state, array, acc, out_valid and out_n go to 0; in_ready=1 after deassertion. Asserting reset mid-frame discards the partial frame.
- The accumulator is OUT_W wide, which is sufficient by construction, so no overflow handling is required.

Decomposition:
- Package smc_pkg:
  - state enum {IDLE, LOAD, SUM, OUT}.
  - Function weight(j, mode0).
  - Functions computing VAL_W and OUT_W from VW and K.
- Sub-module smc_cell_calc (combinational):
  - Inputs W, V_GS, V_DS, mode[0]; output VAL_W value.
  - Reused by the bench as a reference.
- Insertion and accumulation stay in smc_stream.

Test Plan:
- Mode 2'b11, elements (W,V_GS,V_DS) = (3,4,5) (6,3,1) (1,7,7) (2,2,0) (7,7,2) (3,5,4) -> Id values 9,6,12,0,46,16; out_n=262, out_valid 4 cycles after the last accept.
- Same elements, mode 2'b01 -> out_n=51. Mode 2'b10 -> gm values 6,4,4,0,9,8; out_n=23. Mode 2'b00 -> out_n=8.
- All six with V_GS=0, any mode -> out_n=0.
- Frame 1 with idle cycles between accepts, then mode changed mid-frame, then frame 2 back-to-back -> the results of both frames match the first-element mode, and in_ready is low during SUM and OUT.
- rst_n pulsed low after 3 accepts, then a full frame -> one out_valid with the full-frame result only.
- in_valid held high during SUM and OUT -> those elements are dropped, and the next frame starts only after in_ready returns high.
